// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: freezes, squashes and redirects the 5-stage pipeline.
// Optional performance counters are built only when STALL_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             redirect_ex,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             pc_sel_redirect,
    output logic             halted,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] dstall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        ISTALL,
        DSTALL,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        ACT_RST,
        ACT_HALT,
        ACT_DSTALL,
        ACT_REDIRECT,
        ACT_LOAD_USE,
        ACT_ISTALL,
        ACT_SQUASH_DROP,
        ACT_NORMAL
    } action_t;

    state_t  state_q, state_d;
    logic    squash_pending_q, squash_pending_d;
    action_t action;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            squash_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            squash_pending_q <= squash_pending_d;
        end
    end

    // Action selection follows the strict priority list; everything below keys off it.
    always_comb begin
        if (rst) begin
            action = ACT_RST;
        end else if (state_q == HALT || halt_wb) begin
            action = ACT_HALT;
        end else if (dmem_busy) begin
            action = ACT_DSTALL;
        end else if (redirect_ex) begin
            action = ACT_REDIRECT;
        end else if (load_use_stall) begin
            action = ACT_LOAD_USE;
        end else if (imem_busy) begin
            action = ACT_ISTALL;
        end else if (squash_pending_q) begin
            action = ACT_SQUASH_DROP;
        end else begin
            action = ACT_NORMAL;
        end
    end

    always_comb begin
        state_d          = RUN;
        squash_pending_d = squash_pending_q;
        pc_en            = 1'b1;
        if_id_en         = 1'b1;
        id_ex_en         = 1'b1;
        ex_mem_en        = 1'b1;
        mem_wb_en        = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        mem_wb_flush     = 1'b0;
        pc_sel_redirect  = 1'b0;
        halted           = 1'b0;
        unique case (action)
            ACT_RST: begin
                pc_en            = 1'b0;
                if_id_en         = 1'b0;
                id_ex_en         = 1'b0;
                ex_mem_en        = 1'b0;
                mem_wb_en        = 1'b0;
                if_id_flush      = 1'b1;
                id_ex_flush      = 1'b1;
                mem_wb_flush     = 1'b1;
                squash_pending_d = 1'b0;
            end
            ACT_HALT: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                halted    = 1'b1;
                state_d   = HALT;
            end
            ACT_DSTALL: begin
                // Front end frozen; a bubble drains into writeback so no register is written twice.
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_flush = 1'b1;
                state_d      = DSTALL;
            end
            ACT_REDIRECT: begin
                pc_sel_redirect = 1'b1;
                if_id_flush     = 1'b1;
                id_ex_flush     = 1'b1;
                if (imem_busy) begin
                    squash_pending_d = 1'b1;
                    state_d          = ISTALL;
                end
            end
            ACT_LOAD_USE: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
            ACT_ISTALL: begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
                state_d     = ISTALL;
            end
            ACT_SQUASH_DROP: begin
                if_id_flush      = 1'b1;
                squash_pending_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;
    logic [CNT_W-1:0] istall_cnt_q, istall_cnt_d;
    logic [CNT_W-1:0] dstall_cnt_q, dstall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && v != '1) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        load_use_cnt_d = sat_inc(load_use_cnt_q, action == ACT_LOAD_USE);
        istall_cnt_d   = sat_inc(istall_cnt_q, action == ACT_ISTALL);
        dstall_cnt_d   = sat_inc(dstall_cnt_q, action == ACT_DSTALL);
        flush_cnt_d    = sat_inc(flush_cnt_q,
                                 action == ACT_REDIRECT || action == ACT_SQUASH_DROP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_use_cnt_q <= '0;
            istall_cnt_q   <= '0;
            dstall_cnt_q   <= '0;
            flush_cnt_q    <= '0;
        end else begin
            load_use_cnt_q <= load_use_cnt_d;
            istall_cnt_q   <= istall_cnt_d;
            dstall_cnt_q   <= dstall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign load_use_cnt = load_use_cnt_q;
    assign istall_cnt   = istall_cnt_q;
    assign dstall_cnt   = dstall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
`else
    assign load_use_cnt = '0;
    assign istall_cnt   = '0;
    assign dstall_cnt   = '0;
    assign flush_cnt    = '0;
`endif

endmodule
